// File: rtl/div_sequencer_if.sv
// Operand request / result response port of the divider sequencer.
// The sequencer takes the slave side; the client (normalisation datapath) takes the master side.
interface div_sequencer_if #(
    parameter int N = 32
);

    logic         iValid;
    logic [N-1:0] iDividend;
    logic [N-1:0] iDivisor;
    logic         oReady;
    logic         oValid;
    logic [N-1:0] oQuotient;
    logic         oSat;
    logic         oDivZero;
    logic         iReady;

    modport slave (
        input  iValid, iDividend, iDivisor, iReady,
        output oReady, oValid, oQuotient, oSat, oDivZero
    );

    modport master (
        output iValid, iDividend, iDivisor, iReady,
        input  oReady, oValid, oQuotient, oSat, oDivZero
    );

endinterface

// File: rtl/div_sequencer.sv
// Valid/ready front end for the sequential sign-magnitude fixed-point divider.
// Optional feature macro DIV_SEQ_ZERO_BYPASS_EN: answer zero divisors locally without starting the divider.
module div_sequencer #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic           iClk,
    input  logic           iRst,
    div_sequencer_if.slave bus,
    output logic [N-1:0]   oDivDividend,
    output logic [N-1:0]   oDivDivisor,
    output logic           oDivStart,
    input  logic [2*N:0]   iDivQuotient,
    input  logic           iDivComplete
);

    if (Q < 0 || Q >= N - 1) begin : gBadQ
        $error("div_sequencer: Q must lie in 0..N-2");
    end

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        OUT
    } state_e;

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-2:0] MAX_MAG = {(N-1){1'b1}};
    localparam logic [N-2:0] ONE_M   = {{(N-2){1'b0}}, 1'b1};
    localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q;
    logic         ready_q;
    logic         valid_q;
    logic [N-1:0] quotient_q;
    logic         sat_q;
    logic         start_q;
    logic [N-1:0] divDividend_q;
    logic [N-1:0] divDivisor_q;
    logic         opSat_q;

    logic [N-2:0] dividendMag;
    logic [N-2:0] divisorMag;
    logic         dividendMin;
    logic         divisorMin;
    logic [N-1:0] dividendSm_d;
    logic [N-1:0] divisorSm_d;
    logic         opSat_d;
    logic         quotSign;
    logic         quotOver;
    logic [N-2:0] quotLow;
    logic [N-1:0] result_d;
    logic         resultSat_d;

    // Two's complement to sign-magnitude; -2^(N-1) has no magnitude in N-1 bits and clamps.
    always_comb begin
        dividendMin  = (bus.iDividend == MIN_NEG);
        divisorMin   = (bus.iDivisor == MIN_NEG);
        dividendMag  = bus.iDividend[N-1] ? (~bus.iDividend[N-2:0] + ONE_M) : bus.iDividend[N-2:0];
        divisorMag   = bus.iDivisor[N-1] ? (~bus.iDivisor[N-2:0] + ONE_M) : bus.iDivisor[N-2:0];
        dividendSm_d = dividendMin ? {1'b1, MAX_MAG} : {bus.iDividend[N-1], dividendMag};
        divisorSm_d  = divisorMin ? {1'b1, MAX_MAG} : {bus.iDivisor[N-1], divisorMag};
        opSat_d      = dividendMin | divisorMin;
    end

    // Any magnitude bit at or above N-1 is out of range for either sign; a -0 quotient negates to 0.
    always_comb begin
        quotSign    = iDivQuotient[2*N];
        quotOver    = |iDivQuotient[2*N-1:N-1];
        quotLow     = iDivQuotient[N-2:0];
        result_d    = quotSign ? (~{1'b0, quotLow} + ONE_N) : {1'b0, quotLow};
        resultSat_d = 1'b0;
        if (quotOver) begin
            result_d    = quotSign ? MIN_NEG : MAX_POS;
            resultSat_d = 1'b1;
        end
    end

`ifdef DIV_SEQ_ZERO_BYPASS_EN
    logic divZero_q;
    logic divisorZero;

    assign divisorZero  = (bus.iDivisor == '0);
    assign bus.oDivZero = divZero_q;
`else
    assign bus.oDivZero = 1'b0;
`endif

    // Sequencing FSM; the divider has no reset, so SYNC waits for it to report idle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q       <= SYNC;
            ready_q       <= 1'b0;
            valid_q       <= 1'b0;
            quotient_q    <= '0;
            sat_q         <= 1'b0;
            start_q       <= 1'b0;
            divDividend_q <= '0;
            divDivisor_q  <= '0;
            opSat_q       <= 1'b0;
`ifdef DIV_SEQ_ZERO_BYPASS_EN
            divZero_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                SYNC: begin
                    if (iDivComplete) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.iValid) begin
                        ready_q       <= 1'b0;
                        divDividend_q <= dividendSm_d;
                        divDivisor_q  <= divisorSm_d;
                        opSat_q       <= opSat_d;
`ifdef DIV_SEQ_ZERO_BYPASS_EN
                        if (divisorZero) begin
                            state_q    <= OUT;
                            valid_q    <= 1'b1;
                            quotient_q <= bus.iDividend[N-1] ? MIN_NEG : MAX_POS;
                            sat_q      <= 1'b1;
                            divZero_q  <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state_q <= START;
                            start_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!iDivComplete) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (iDivComplete) begin
                        state_q    <= OUT;
                        valid_q    <= 1'b1;
                        quotient_q <= result_d;
                        sat_q      <= resultSat_d | opSat_q;
`ifdef DIV_SEQ_ZERO_BYPASS_EN
                        divZero_q  <= 1'b0;
`endif
                    end
                end
                OUT: begin
                    if (bus.iReady) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SYNC;
                end
            endcase
        end
    end

    assign bus.oReady    = ready_q;
    assign bus.oValid    = valid_q;
    assign bus.oQuotient = quotient_q;
    assign bus.oSat      = sat_q;
    assign oDivStart     = start_q;
    assign oDivDividend  = divDividend_q;
    assign oDivDivisor   = divDivisor_q;

endmodule
